// File: rtl/snn_pkg.sv
// Shared types and defaults for the spiking-network AER blocks.
package snn_pkg;

    // Default timestep counter width.
    localparam int TS_W_DEF = 16;

    // Widest event address carried by the shared event format.
    localparam int AER_AW_MAX = 8;

    // Output register occupancy.
    typedef enum logic {
        AER_EMPTY = 1'b0,
        AER_FULL  = 1'b1
    } aer_state_e;

    // Address-event as seen by the router and spike logger.
    typedef struct packed {
        logic [AER_AW_MAX-1:0] addr;
        logic [TS_W_DEF-1:0]   tstamp;
    } aer_event_t;

endpackage

// File: rtl/spike_aer_arbiter_if.sv
// Address-event channel: valid/ready handshake carrying neuron index and timestep.
interface spike_aer_arbiter_if #(
    parameter int AW   = 2,
    parameter int TS_W = snn_pkg::TS_W_DEF
);
    logic            aer_valid;
    logic            aer_ready;
    logic [AW-1:0]   aer_addr;
    logic [TS_W-1:0] aer_time;

    modport master (output aer_valid, output aer_addr, output aer_time, input aer_ready);
    modport slave  (input aer_valid, input aer_addr, input aer_time, output aer_ready);
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational N-way round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [AW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [AW-1:0] o_idx,
    output logic          o_any
);

    // Scan offsets from farthest to nearest so the request closest to ptr wins.
    always_comb begin
        logic [AW-1:0] w_k;
        w_k     = '0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = AW'((int'(i_ptr) + i) % N);
            if (i_req[w_k]) begin
                o_grant      = '0;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_aer_arbiter.sv
// Collects neuron spikes into a pending register and serialises them
// round-robin onto a single-entry AER output register.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   AER_EMPTY | no event held, aer_valid low
//   AER_FULL  | event held on aer_addr/aer_time, aer_valid high
module spike_aer_arbiter
    import snn_pkg::*;
#(
    parameter int N    = 4,
    parameter int AW   = $clog2(N),
    parameter int TS_W = TS_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        i_spike_vec,
    input  logic                i_step,
    input  logic                i_ovf_clr,
    output logic                o_ovf,
    output logic                o_busy,
    spike_aer_arbiter_if.master aer
);

    aer_state_e      r_state;
    aer_state_e      w_state_nxt;
    logic [N-1:0]    r_pend;
    logic [N-1:0]    w_grant;
    logic [N-1:0]    w_grant_eff;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_gnt_idx;
    logic [AW-1:0]   r_addr;
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_time;
    logic            r_ovf;
    logic            w_any;
    logic            w_load;
    logic            w_ovf_set;

    rr_priority_picker #(.N(N), .AW(AW)) u_picker (
        .i_req   (r_pend),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx),
        .o_any   (w_any)
    );

    // Output register occupancy state.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= AER_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // A held event only leaves on a handshake; a refill keeps the register full.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AER_EMPTY: if (w_any) w_state_nxt = AER_FULL;
            AER_FULL:  if (aer.aer_ready && !w_any) w_state_nxt = AER_EMPTY;
            default:   w_state_nxt = AER_EMPTY;
        endcase
    end

    // Load a new grant whenever the output register is free or being drained.
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            AER_EMPTY: w_load = w_any;
            AER_FULL:  w_load = aer.aer_ready && w_any;
            default:   w_load = 1'b0;
        endcase
    end

    // A spike on the bit being granted is a fresh event, so only ungranted bits overflow.
    assign w_grant_eff = w_load ? w_grant : '0;
    assign w_ovf_set   = |(i_spike_vec & r_pend & ~w_grant_eff);

    // Pending bits, pointer, timestep, event payload and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend <= '0;
            r_ptr  <= '0;
            r_ts   <= '0;
            r_addr <= '0;
            r_time <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant_eff) | i_spike_vec;
            if (i_step) r_ts <= r_ts + 1'b1;
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (i_ovf_clr) r_ovf <= 1'b0;
            if (w_load) begin
                r_addr <= w_gnt_idx;
                r_time <= r_ts;
                r_ptr  <= (w_gnt_idx == AW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign aer.aer_valid = (r_state == AER_FULL);
    assign aer.aer_addr  = r_addr;
    assign aer.aer_time  = r_time;
    assign o_ovf         = r_ovf;
    assign o_busy        = (r_state == AER_FULL) || (|r_pend);

endmodule

// File: doc/spike_aer_arbiter.md
# spike_aer_arbiter

Round-robin arbiter that collects spikes from an `N`-neuron LIF array and serialises them onto a single address-event (AER) output channel.
- Sits directly downstream of the neuron array's `spike_out` vector.
- Holds one pending bit per neuron and grants fairly among them.
- Presents one event per handshake, tagged with the current timestep.
- Feeds the inter-layer router and the spike logger.

## Interface
- `N`, 4: number of neurons served; must be ≥2.
- `AW`, `$clog2(N)`: event address width.
- `TS_W`, 16: timestep counter width.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `spike_vec`  in  N  spike outputs from the neuron array; one-cycle pulses, any number set per cycle.
- `step`  in  1  timestep-boundary pulse; increments the timestep counter.
- `aer_valid`  out  1  event present on `aer_addr`/`aer_time`.
- `aer_ready`  in  1  consumer accepts the event when high together with `aer_valid`.
- `aer_addr`  out  AW  index of the spiking neuron.
- `aer_time`  out  TS_W  timestep at which the event was loaded.
- `ovf`  out  1  sticky flag: a spike merged into an already-pending bit.
- `ovf_clr`  in  1  clears `ovf`.
- `busy`  out  1  `aer_valid` OR any pending bit set.

## Operation
- **Pending register** `pend[N-1:0]`:
  - Each cycle, `pend <= (pend & ~grant_onehot) | spike_vec`.
  - A spike on a bit that is already set and not granted this cycle sets `ovf`. The spike is merged, not queued.
  - A spike on the bit being granted in the same cycle leaves the bit set and does not set `ovf`; it is a new event.
- **Output register** (single entry) has two states:
  - EMPTY (`aer_valid=0`):
    - if `pend≠0`, load a grant → FULL;
    - else stay EMPTY.
  - FULL (`aer_valid=1`):
    - `aer_ready=0`: hold `aer_addr`/`aer_time` stable → FULL.
    - `aer_ready=1` and `pend≠0`: load the next grant in the same cycle → FULL (back-to-back, one event per cycle).
    - `aer_ready=1` and `pend=0` → EMPTY.
- **Grant rule**:
  - Pick the lowest index ≥ `ptr`, wrapping modulo N, with `pend` set.
  - On each load, `ptr <= (granted+1) mod N`; at `granted=N-1`, `ptr` wraps to 0.
  - `ptr` is unchanged when nothing loads.
- **Timestep counter** `ts`:
  - `ts <= ts+1` on `step`, wrapping from 2^TS_W−1 to 0.
  - `aer_time` captures the pre-increment value of `ts` at load, including when `step` is high in the load cycle.
- **`ovf`**:
  - Set takes priority over `ovf_clr` in the same cycle.
  - Cleared only by `ovf_clr` or reset.
- **Reset** (`reset=0` at an edge): `pend`, `ptr`, `ts`, `aer_valid`, `aer_addr`, `aer_time`, `ovf` all go to 0, so `busy=0`.
  - An in-flight event is dropped; the consumer must not expect it after reset.
  - `spike_vec` is ignored during reset cycles.

## Timing
- Latency: a spike high in cycle c gives `aer_valid` in cycle c+2 at the earliest (pending register, then output register).
- Throughput: 1 event/cycle while `aer_ready=1` and `pend≠0`.
- Fairness: with all N bits continuously pending, every neuron is granted once per N accepted events.
- `aer_valid` never drops without a handshake, except on reset.
- `aer_addr` and `aer_time` are stable while `aer_valid & ~aer_ready`.
- All outputs are registered except `busy` (combinational OR of registered state).

## Structure
- Shared package `snn_pkg` holds:
  - the output state enum (`AER_EMPTY`, `AER_FULL`);
  - the AER event struct (`addr`, `time`);
  - the default `TS_W` constant.
- Sub-module `rr_priority_picker`: combinational N-way round-robin pick.
  - Inputs: request vector, `ptr`.
  - Outputs: one-hot grant, binary index, `any`.
  - It is reused by the router arbiter.

## Test plan
- **Single spike:** after reset, `spike_vec=4'b0100` for one cycle at c=5 → `aer_valid` at c=7 with `aer_addr=2`, `aer_time=0`; `busy` clears after accept.
- **Burst:** `spike_vec=4'b1111` in one cycle with `aer_ready=1` → four consecutive events, addr 0,1,2,3; then `aer_valid=0`.
- **Backpressure:** hold `aer_ready=0` for 10 cycles with an event at addr 1 → addr and time unchanged. Spike neuron 1 twice more → `ovf=1`. Release ready → exactly one further addr-1 event.
- **Fairness/wrap:** `ptr` at 3 with pending {0,3} → grant order 3 then 0. Pulse `ovf_clr` → `ovf=0`.
- **Timestep:** 65536 `step` pulses then a spike → `aer_time=0` (wrap). `step` coincident with load → event carries the old `ts`.
- **Reset mid-operation:** assert `reset=0` with `aer_valid=1` and `pend=4'b1010` → next cycle all outputs 0. No stale event appears after reset release.
